// File: rtl/addr_range_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : addr_range_monitor                                           |
// | Description : Passive, bindable address-range checker. Compares every      |
// |               valid access against NUM_WIN programmable inclusive windows |
// |               and reports out-of-range accesses through a pulse, a sticky |
// |               flag, a first-violation address capture, a saturating       |
// |               counter and a threshold interrupt.                          |
// |               Optional macro ADDR_RANGE_MONITOR_ASSERT_EN compiles in a    |
// |               violation assertion and an IDLE->TRIPPED cover property.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module addr_range_monitor #(
  parameter int ADDR_W     = 8,
  parameter int NUM_WIN    = 4,
  parameter int CNT_W      = 8,
  parameter int IRQ_THRESH = 1,
  localparam int IDX_W     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_valid,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_lo,
  input  logic [ADDR_W-1:0] cfg_hi,
  input  logic              clr,
  output logic              viol_pulse,
  output logic              viol_sticky,
  output logic [ADDR_W-1:0] viol_addr,
  output logic [CNT_W-1:0]  viol_count,
  output logic              irq
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(IRQ_THRESH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_TRIPPED  = 2'd2
  } state_t;

  logic [NUM_WIN-1:0] en_q;
  logic [ADDR_W-1:0]  lo_q [NUM_WIN];
  logic [ADDR_W-1:0]  hi_q [NUM_WIN];

  logic [NUM_WIN-1:0] w_match;
  logic               w_armed;
  logic               w_viol;

  state_t             state_q, state_d;
  logic               pulse_q, pulse_d;
  logic               sticky_q, sticky_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Per-window inclusive unsigned range match; lo > hi can never satisfy both.
  for (genvar g = 0; g < NUM_WIN; g++) begin : g_match
    assign w_match[g] = en_q[g] && (acc_addr >= lo_q[g]) && (acc_addr <= hi_q[g]);
  end

  assign w_armed = |en_q;
  assign w_viol  = acc_valid && w_armed && !(|w_match);

  // Window register file; indices that name no window are silently dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int w = 0; w < NUM_WIN; w++) begin
        lo_q[w] <= '0;
        hi_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WIN; w++) begin
        if (cfg_we && (cfg_idx == IDX_W'(w))) begin
          en_q[w] <= cfg_en;
          lo_q[w] <= cfg_lo;
          hi_q[w] <= cfg_hi;
        end
      end
    end
  end

  // Status and state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
    end
  end

  // Next-state: clr outranks a concurrent violation; capture only from IDLE.
  always_comb begin
    state_d  = state_q;
    pulse_d  = 1'b0;
    sticky_d = sticky_q;
    addr_d   = addr_q;
    count_d  = count_q;
    if (clr) begin
      state_d  = ST_IDLE;
      sticky_d = 1'b0;
      addr_d   = '0;
      count_d  = '0;
    end else if (w_viol) begin
      pulse_d  = 1'b1;
      sticky_d = 1'b1;
      count_d  = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
      if (state_q == ST_IDLE) begin
        addr_d = acc_addr;
      end
      if (state_q != ST_TRIPPED) begin
        state_d = (count_d >= THRESH_C) ? ST_TRIPPED : ST_COUNTING;
      end
    end
  end

  assign viol_pulse  = pulse_q;
  assign viol_sticky = sticky_q;
  assign viol_addr   = addr_q;
  assign viol_count  = count_q;
  assign irq         = (state_q == ST_TRIPPED);

`ifdef ADDR_RANGE_MONITOR_ASSERT_EN
  // Flags every out-of-range access as it is sampled.
  a_no_violation : assert property (@(posedge clk) disable iff (!rst_n) !w_viol)
    else $error("addr_range_monitor: out-of-range access at address 0x%0h", acc_addr);

  // Direct trip from a clean state (reachable when the threshold is 1).
  c_idle_to_tripped : cover property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_IDLE) ##1 (state_q == ST_TRIPPED));
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_addr_range_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_addr_range_monitor                                        |
// | Description : Self-checking bench for addr_range_monitor: directed steps   |
// |               followed by random traffic, compared against a behavioural  |
// |               model of windows, status and interrupt.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_addr_range_monitor;

  localparam int ADDR_W  = 8;
  localparam int NUM_WIN = 3;
  localparam int CNT_W   = 2;
  localparam int THRESH  = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              acc_valid;
  logic [ADDR_W-1:0] acc_addr;
  logic              cfg_we;
  logic [1:0]        cfg_idx;
  logic              cfg_en;
  logic [ADDR_W-1:0] cfg_lo;
  logic [ADDR_W-1:0] cfg_hi;
  logic              clr;
  logic              viol_pulse;
  logic              viol_sticky;
  logic [ADDR_W-1:0] viol_addr;
  logic [CNT_W-1:0]  viol_count;
  logic              irq;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit m_en [NUM_WIN];
  int m_lo [NUM_WIN];
  int m_hi [NUM_WIN];
  bit m_pulse, m_sticky, m_irq;
  int m_addr, m_cnt;

  always #5 clk = ~clk;

  addr_range_monitor #(
    .ADDR_W    (ADDR_W),
    .NUM_WIN   (NUM_WIN),
    .CNT_W     (CNT_W),
    .IRQ_THRESH(THRESH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_valid  (acc_valid),
    .acc_addr   (acc_addr),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .clr        (clr),
    .viol_pulse (viol_pulse),
    .viol_sticky(viol_sticky),
    .viol_addr  (viol_addr),
    .viol_count (viol_count),
    .irq        (irq)
  );

  task automatic model_edge();
    bit inside_any;
    bit armed;
    bit v;
    inside_any = 1'b0;
    armed      = 1'b0;
    if (!rst_n) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        m_en[w] = 1'b0; m_lo[w] = 0; m_hi[w] = 0;
      end
      m_pulse = 0; m_sticky = 0; m_addr = 0; m_cnt = 0; m_irq = 0;
      return;
    end
    for (int w = 0; w < NUM_WIN; w++) begin
      if (m_en[w]) armed = 1'b1;
      if (m_en[w] && int'(acc_addr) >= m_lo[w] && int'(acc_addr) <= m_hi[w])
        inside_any = 1'b1;
    end
    v = acc_valid && armed && !inside_any;
    if (cfg_we && int'(cfg_idx) < NUM_WIN) begin
      m_en[cfg_idx] = cfg_en;
      m_lo[cfg_idx] = int'(cfg_lo);
      m_hi[cfg_idx] = int'(cfg_hi);
    end
    if (clr) begin
      m_pulse = 0; m_sticky = 0; m_addr = 0; m_cnt = 0;
    end else begin
      m_pulse = v;
      if (v) begin
        if (!m_sticky) m_addr = int'(acc_addr);
        m_sticky = 1;
        m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
    end
    // count only falls on clr, so "tripped" is simply count at/above threshold
    m_irq = (m_cnt >= THRESH);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("viol_pulse",  32'(viol_pulse),  32'(m_pulse));
    chk("viol_sticky", 32'(viol_sticky), 32'(m_sticky));
    chk("viol_addr",   32'(viol_addr),   32'(m_addr));
    chk("viol_count",  32'(viol_count),  32'(m_cnt));
    chk("irq",         32'(irq),         32'(m_irq));
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic run_cycle();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst_n = 1'b1; acc_valid = 1'b0; acc_addr = '0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_en = 1'b0; cfg_lo = '0; cfg_hi = '0; clr = 1'b0;
  endtask

  task automatic acc(input logic [7:0] a);
    idle_in(); acc_valid = 1'b1; acc_addr = a; run_cycle();
  endtask

  task automatic wcfg(input logic [1:0] i, input logic e, input logic [7:0] l, input logic [7:0] h);
    idle_in(); cfg_we = 1'b1; cfg_idx = i; cfg_en = e; cfg_lo = l; cfg_hi = h; run_cycle();
  endtask

  task automatic do_clr();
    idle_in(); clr = 1'b1; run_cycle();
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    run_cycle();
    run_cycle();

    // disarmed: nothing is a violation
    for (int i = 0; i < 10; i++) acc(8'hFF);

    // single window 0x10..0x7F, boundaries inside, 0x80 outside
    wcfg(2'd0, 1'b1, 8'h10, 8'h7F);
    acc(8'h10); acc(8'h7F); acc(8'h80); acc(8'h20);

    // threshold trip after three violations, capture holds first one, saturation
    do_clr();
    acc(8'h90); acc(8'hA0); acc(8'hB0);
    acc(8'hC0); acc(8'hD0); acc(8'hE0);
    do_clr();

    // same-cycle cfg write and access: checked against old windows
    idle_in(); cfg_we = 1'b1; cfg_idx = 2'd1; cfg_en = 1'b1; cfg_lo = 8'h80; cfg_hi = 8'hFF;
    acc_valid = 1'b1; acc_addr = 8'h90;
    run_cycle();
    acc(8'h90);

    // clr coincident with a violation discards it
    idle_in(); clr = 1'b1; acc_valid = 1'b1; acc_addr = 8'h05;
    run_cycle();

    // out-of-range index is ignored; 0x05 must still violate
    wcfg(2'd3, 1'b1, 8'h00, 8'h0F);
    acc(8'h05);

    // lo > hi window never matches
    wcfg(2'd2, 1'b1, 8'h08, 8'h02);
    acc(8'h05);

    // reset mid-burst
    acc(8'h06);
    idle_in(); rst_n = 1'b0; acc_valid = 1'b1; acc_addr = 8'h07;
    run_cycle();
    acc(8'h07);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      idle_in();
      acc_valid = ($urandom_range(0, 3) != 0);
      acc_addr  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        cfg_we  = 1'b1;
        cfg_idx = 2'($urandom);
        cfg_en  = ($urandom_range(0, 3) != 0);
        cfg_lo  = 8'($urandom);
        cfg_hi  = 8'($urandom);
      end
      clr   = ($urandom_range(0, 24) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
